// File: rtl/serializador.sv
// Serial link transmitter: 8-bit words shifted out LSB first, one bit per clock,
// with a one-word holding buffer. Define SERIALIZADOR_PARITY_EN to append an even-parity bit.
module serializador #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock_100KHz,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  load_in,
    output logic                  status_out,
    input  logic                  status_in,
    output logic                  data_out,
    output logic                  write_out,
    output logic [7:0]            sent_count
);

    // state     | meaning
    // S_IDLE    | waiting for a buffered word and a ready receiver
    // S_SENDING | burst in progress, write_out high
    // S_WAIT_RX | burst done, waiting for receiver to drop status_in
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SENDING = 2'd1;
    localparam logic [1:0] S_WAIT_RX = 2'd2;

    localparam int CNT_W = $clog2(DATA_WIDTH + 1) + 1;
`ifdef SERIALIZADOR_PARITY_EN
    localparam int BURST_LEN = DATA_WIDTH + 1;
`else
    localparam int BURST_LEN = DATA_WIDTH;
`endif
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic                  buf_valid_q, buf_valid_d;
    logic                  status_q, status_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  data_q, data_d;
    logic                  write_q, write_d;
    logic [7:0]            sent_q, sent_d;
    logic                  drain;
`ifdef SERIALIZADOR_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    // Load is gated by the registered empty flag, so it can never coincide with a drain.
    assign drain = (state_q == S_IDLE) && buf_valid_q && status_in;

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        write_d     = write_q;
        sent_d      = sent_q;
`ifdef SERIALIZADOR_PARITY_EN
        parity_d    = parity_q;
`endif

        if (drain) begin
            buf_valid_d = 1'b0;
        end else if (load_in && status_q) begin
            buf_d       = data_in;
            buf_valid_d = 1'b1;
        end
        status_d = ~buf_valid_d;

        case (state_q)
            S_IDLE: begin
                write_d = 1'b0;
                data_d  = 1'b0;
                if (drain) begin
                    shift_d = buf_q;
                    data_d  = buf_q[0];
                    write_d = 1'b1;
                    cnt_d   = CNT_START;
`ifdef SERIALIZADOR_PARITY_EN
                    parity_d = ^buf_q;
`endif
                    state_d = S_SENDING;
                end
            end
            S_SENDING: begin
                if (cnt_q != '0) begin
                    cnt_d   = cnt_q - CNT_ONE;
                    shift_d = shift_q >> 1;
                    data_d  = shift_q[1];
`ifdef SERIALIZADOR_PARITY_EN
                    if (cnt_q == CNT_ONE) data_d = parity_q;
`endif
                    write_d = 1'b1;
                end else begin
                    write_d = 1'b0;
                    data_d  = 1'b0;
                    sent_d  = sent_q + 8'd1;
                    state_d = S_WAIT_RX;
                end
            end
            S_WAIT_RX: begin
                write_d = 1'b0;
                data_d  = 1'b0;
                if (!status_in) state_d = S_IDLE;
            end
            default: begin
                write_d = 1'b0;
                data_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_100KHz or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            status_q    <= 1'b1;
            shift_q     <= '0;
            cnt_q       <= '0;
            data_q      <= 1'b0;
            write_q     <= 1'b0;
            sent_q      <= 8'd0;
`ifdef SERIALIZADOR_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            status_q    <= status_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            write_q     <= write_d;
            sent_q      <= sent_d;
`ifdef SERIALIZADOR_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign status_out = status_q;
    assign data_out   = data_q;
    assign write_out  = write_q;
    assign sent_count = sent_q;

endmodule

// File: tb/tb_serializador.sv
// Directed self-checking bench for serializador; inputs driven and outputs sampled on the falling edge.
module tb_serializador;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in;
    logic       load_in;
    logic       status_out;
    logic       status_in;
    logic       data_out;
    logic       write_out;
    logic [7:0] sent_count;

    int compared   = 0;
    int mismatched = 0;

`ifdef SERIALIZADOR_PARITY_EN
    localparam int EXP_LEN = 9;
`else
    localparam int EXP_LEN = 8;
`endif

    serializador #(.DATA_WIDTH(8)) dut (
        .clock_100KHz(clk),
        .reset       (rst_n),
        .data_in     (data_in),
        .load_in     (load_in),
        .status_out  (status_out),
        .status_in   (status_in),
        .data_out    (data_out),
        .write_out   (write_out),
        .sent_count  (sent_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [8:0] exp_word(input logic [7:0] d);
`ifdef SERIALIZADOR_PARITY_EN
        return {^d, d};
`else
        return {1'b0, d};
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic load_word(input logic [7:0] d);
        data_in = d;
        load_in = 1'b1;
        @(negedge clk);
        load_in = 1'b0;
    endtask

    // Waits (bounded) for write_out, then collects bits until it drops.
    // Optionally pulses load_in during burst bit index load_at.
    task automatic get_burst(input int load_at, input logic [7:0] load_data,
                             output logic [8:0] word, output int nbits,
                             output logic st_at_load);
        int wait_cyc;
        wait_cyc   = 0;
        word       = '0;
        nbits      = 0;
        st_at_load = 1'b0;
        while (write_out !== 1'b1 && wait_cyc < 60) begin
            @(negedge clk);
            wait_cyc++;
        end
        while (write_out === 1'b1 && nbits < 16) begin
            if (nbits < 9) word[nbits] = data_out;
            if (nbits == load_at) begin
                st_at_load = status_out;
                data_in    = load_data;
                load_in    = 1'b1;
            end else begin
                load_in = 1'b0;
            end
            nbits++;
            @(negedge clk);
        end
        load_in = 1'b0;
    endtask

    initial begin
        logic [8:0] w;
        int         nb;
        logic       st;
        logic       any_w;
        logic [7:0] d;
        logic [7:0] exp_cnt;
        logic [7:0] prev_cnt;
        logic       wrap_seen;

        rst_n     = 1'b0;
        data_in   = 8'h00;
        load_in   = 1'b0;
        status_in = 1'b0;
        step(3);
        check("rst_status_out", 32'(status_out), 32'd1);
        check("rst_write_out",  32'(write_out),  32'd0);
        check("rst_data_out",   32'(data_out),   32'd0);
        check("rst_sent_count", 32'(sent_count), 32'd0);
        rst_n = 1'b1;
        step(2);

        // 1: single word A5 with receiver ready
        status_in = 1'b1;
        load_word(8'hA5);
        check("t1_status_low",   32'(status_out), 32'd0);
        check("t1_no_write_yet", 32'(write_out),  32'd0);
        step(1);
        check("t1_status_back",  32'(status_out), 32'd1);
        check("t1_write_start",  32'(write_out),  32'd1);
        check("t1_bit0",         32'(data_out),   32'd1);
        get_burst(-1, 8'h00, w, nb, st);
        check("t1_word",  32'(w),  32'(exp_word(8'hA5)));
        check("t1_len",   32'(nb), 32'(EXP_LEN));
        check("t1_count", 32'(sent_count), 32'd1);
        check("t1_data_idle", 32'(data_out), 32'd0);

        // 2: receiver busy, buffered word held; second load ignored
        status_in = 1'b0;
        step(2);
        load_word(8'h3C);
        any_w = 1'b0;
        for (int i = 0; i < 6; i++) begin
            any_w |= write_out;
            step(1);
        end
        check("t2_no_burst",   32'(any_w),      32'd0);
        check("t2_status_low", 32'(status_out), 32'd0);
        load_word(8'hFF);
        step(1);
        check("t2_status_still_low", 32'(status_out), 32'd0);
        status_in = 1'b1;
        get_burst(-1, 8'h00, w, nb, st);
        check("t2_word",  32'(w),  32'(exp_word(8'h3C)));
        check("t2_len",   32'(nb), 32'(EXP_LEN));
        check("t2_count", 32'(sent_count), 32'd2);

        // 3: load 42 during the 81 burst; 42 waits for a receiver ack
        status_in = 1'b0;
        step(2);
        status_in = 1'b1;
        load_word(8'h81);
        get_burst(0, 8'h42, w, nb, st);
        check("t3_status_at_load", 32'(st), 32'd1);
        check("t3_word81",  32'(w),  32'(exp_word(8'h81)));
        check("t3_len81",   32'(nb), 32'(EXP_LEN));
        check("t3_count81", 32'(sent_count), 32'd3);
        check("t3_buffered_status", 32'(status_out), 32'd0);
        any_w = 1'b0;
        for (int i = 0; i < 12; i++) begin
            any_w |= write_out;
            step(1);
        end
        check("t3_hold_until_ack", 32'(any_w), 32'd0);
        status_in = 1'b0;
        any_w = 1'b0;
        for (int i = 0; i < 3; i++) begin
            any_w |= write_out;
            step(1);
        end
        check("t3_hold_while_busy", 32'(any_w), 32'd0);
        status_in = 1'b1;
        get_burst(-1, 8'h00, w, nb, st);
        check("t3_word42",  32'(w),  32'(exp_word(8'h42)));
        check("t3_count42", 32'(sent_count), 32'd4);

        // 4: asynchronous reset in the middle of F0
        status_in = 1'b0;
        step(2);
        status_in = 1'b1;
        load_word(8'hF0);
        for (int i = 0; i < 20 && write_out !== 1'b1; i++) step(1);
        check("t4_burst_started", 32'(write_out), 32'd1);
        step(2);
        #2 rst_n = 1'b0;
        #1;
        check("t4_rst_write",  32'(write_out),  32'd0);
        check("t4_rst_data",   32'(data_out),   32'd0);
        check("t4_rst_count",  32'(sent_count), 32'd0);
        check("t4_rst_status", 32'(status_out), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        any_w = 1'b0;
        for (int i = 0; i < 15; i++) begin
            any_w |= write_out;
            step(1);
        end
        check("t4_idle_after_rst", 32'(any_w), 32'd0);
        load_word(8'h5A);
        get_burst(-1, 8'h00, w, nb, st);
        check("t4_word5A",  32'(w),  32'(exp_word(8'h5A)));
        check("t4_count5A", 32'(sent_count), 32'd1);

        // 5: 256 words through a modelled receiver, sent_count wraps
        exp_cnt   = 8'd1;
        wrap_seen = 1'b0;
        for (int i = 0; i < 256; i++) begin
            d = 8'(i * 37 + 11);
            status_in = 1'b0;
            step(1);
            status_in = 1'b1;
            load_word(d);
            prev_cnt = sent_count;
            get_burst(-1, 8'h00, w, nb, st);
            exp_cnt = exp_cnt + 8'd1;
            check("t5_word",  32'(w),  32'(exp_word(d)));
            check("t5_len",   32'(nb), 32'(EXP_LEN));
            check("t5_count", 32'(sent_count), 32'(exp_cnt));
            if (prev_cnt == 8'd255 && sent_count == 8'd0) wrap_seen = 1'b1;
        end
        check("t5_wrap_seen", 32'(wrap_seen), 32'd1);

`ifdef SERIALIZADOR_PARITY_EN
        // 6: parity bit appended
        status_in = 1'b0;
        step(1);
        status_in = 1'b1;
        load_word(8'h07);
        get_burst(-1, 8'h00, w, nb, st);
        check("t6_word07", 32'(w),  32'h107);
        check("t6_len07",  32'(nb), 32'd9);
        status_in = 1'b0;
        step(1);
        status_in = 1'b1;
        load_word(8'h03);
        get_burst(-1, 8'h00, w, nb, st);
        check("t6_word03", 32'(w),  32'h003);
        check("t6_len03",  32'(nb), 32'd9);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
